// File: rtl/snake_body_engine.sv
// Snake state engine: segment storage, move/grow/collision logic, and the
// registered per-pixel cell classifier used by the renderer.
module snake_body_engine #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 20,
    parameter int INIT_Y   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic       move_tick,
    input  logic [1:0] dir_in,
    input  logic [1:0] game_status,
    input  logic [5:0] apple_x,
    input  logic [4:0] apple_y,
    output logic [1:0] snake,
    output logic       apple_eaten,
    output logic       hit_wall,
    output logic       hit_body,
    output logic [5:0] length
);
    localparam logic [1:0] DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11;
    localparam logic [1:0] GS_RESTART = 2'b00, GS_PLAY = 2'b10;
    localparam logic [1:0] Q_NONE = 2'b00, Q_HEAD = 2'b01, Q_BODY = 2'b10, Q_WALL = 2'b11;

    logic [5:0] r_seg_x [MAX_LEN];
    logic [4:0] r_seg_y [MAX_LEN];
    logic [5:0] r_len;
    logic [1:0] r_cur_dir, r_pend_dir, r_snake;
    logic       r_apple_eaten, r_hit_wall, r_hit_body;

    logic [5:0] w_nx;
    logic [4:0] w_ny;
    logic       w_restart, w_move, w_wall_hit, w_body_hit, w_apple;
    logic [5:0] w_qx, w_qy;
    logic       w_q_body;
    logic [1:0] w_qcode;

    function automatic logic [1:0] reverse_dir(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    assign w_restart = rst || (game_status == GS_RESTART);
    assign w_move    = move_tick && (game_status == GS_PLAY) && !r_hit_wall && !r_hit_body;
    assign w_qx      = x_pos[9:4];
    assign w_qy      = y_pos[9:4];

    // Candidate head cell uses the pending direction, which becomes current on a move.
    always_comb begin
        w_nx = r_seg_x[0];
        w_ny = r_seg_y[0];
        case (r_pend_dir)
            DIR_UP:    w_ny = r_seg_y[0] - 5'd1;
            DIR_DOWN:  w_ny = r_seg_y[0] + 5'd1;
            DIR_LEFT:  w_nx = r_seg_x[0] - 6'd1;
            default:   w_nx = r_seg_x[0] + 6'd1;
        endcase
    end

    assign w_wall_hit = (w_nx == 6'd0) || (w_nx == 6'd39) || (w_ny == 5'd0) || (w_ny == 5'd29);
    assign w_apple    = (w_nx == apple_x) && (w_ny == apple_y);

    // The tail (index length-1) vacates on this move, so it cannot cause a self hit.
    always_comb begin
        w_body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i < int'(r_len) - 1) && (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny))
                w_body_hit = 1'b1;
        end
    end

    always_comb begin
        w_q_body = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i < int'(r_len)) && (r_seg_x[i] == w_qx) && ({1'b0, r_seg_y[i]} == w_qy))
                w_q_body = 1'b1;
        end
        w_qcode = Q_NONE;
        if ((w_qx < 6'd40) && (w_qy < 6'd30)) begin
            if ((w_qx == 6'd0) || (w_qx == 6'd39) || (w_qy == 6'd0) || (w_qy == 6'd29))
                w_qcode = Q_WALL;
            else if ((w_qx == r_seg_x[0]) && (w_qy == {1'b0, r_seg_y[0]}))
                w_qcode = Q_HEAD;
            else if (w_q_body)
                w_qcode = Q_BODY;
        end
    end

    always_ff @(posedge clk) begin
        if (w_restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < INIT_LEN) ? 6'(INIT_X - i) : 6'd0;
                r_seg_y[i] <= 5'(INIT_Y);
            end
            r_len         <= 6'(INIT_LEN);
            r_cur_dir     <= DIR_RIGHT;
            r_pend_dir    <= DIR_RIGHT;
            r_snake       <= Q_NONE;
            r_apple_eaten <= 1'b0;
            r_hit_wall    <= 1'b0;
            r_hit_body    <= 1'b0;
        end else begin
            r_snake       <= w_qcode;
            r_apple_eaten <= 1'b0;
            if (game_status == GS_PLAY) begin
                if (dir_in != reverse_dir(r_cur_dir))
                    r_pend_dir <= dir_in;
                if (w_move) begin
                    if (w_wall_hit) begin
                        r_hit_wall <= 1'b1;
                    end else if (w_body_hit) begin
                        r_hit_body <= 1'b1;
                    end else begin
                        // Shifting every slot keeps the old tail as the new tail on growth.
                        for (int i = 1; i < MAX_LEN; i++) begin
                            r_seg_x[i] <= r_seg_x[i-1];
                            r_seg_y[i] <= r_seg_y[i-1];
                        end
                        r_seg_x[0] <= w_nx;
                        r_seg_y[0] <= w_ny;
                        r_cur_dir  <= r_pend_dir;
                        if (w_apple) begin
                            r_apple_eaten <= 1'b1;
                            if (r_len < 6'(MAX_LEN))
                                r_len <= r_len + 6'd1;
                        end
                    end
                end
            end
        end
    end

    assign snake       = r_snake;
    assign apple_eaten = r_apple_eaten;
    assign hit_wall    = r_hit_wall;
    assign hit_body    = r_hit_body;
    assign length      = r_len;
endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: a reset query table, directed move/grow/collision
// sequences, and randomized play against a queue-based snake model.
module tb_snake_body_engine;
    localparam int MAX_LEN = 16, INIT_LEN = 3, INIT_X = 20, INIT_Y = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x_pos = '0, y_pos = '0;
    logic       move_tick = 1'b0;
    logic [1:0] dir_in = 2'd3;
    logic [1:0] game_status = 2'b01;
    logic [5:0] apple_x = 6'd5;
    logic [4:0] apple_y = 5'd5;
    logic [1:0] snake;
    logic       apple_eaten, hit_wall, hit_body;
    logic [5:0] length;

    snake_body_engine #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .INIT_X(INIT_X), .INIT_Y(INIT_Y)) dut (
        .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos), .move_tick(move_tick),
        .dir_in(dir_in), .game_status(game_status), .apple_x(apple_x), .apple_y(apple_y),
        .snake(snake), .apple_eaten(apple_eaten), .hit_wall(hit_wall), .hit_body(hit_body),
        .length(length)
    );

    always #5 clk = ~clk;

    int tests = 0, failed = 0;

    // Reference model: the snake is a queue of cells, head at the front.
    int  mx[$], my[$];
    int  m_cur, m_pend;
    bit  m_hw, m_hb;
    int  e_snake, e_eat;

    typedef struct { int x; int y; int exp; } qvec_t;
    qvec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit opposite(input int a, input int b);
        return (a == 0 && b == 1) || (a == 1 && b == 0) || (a == 2 && b == 3) || (a == 3 && b == 2);
    endfunction

    function automatic int m_query(input int cx, input int cy);
        if (cx >= 40 || cy >= 30) return 0;
        if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return 3;
        if (cx == mx[0] && cy == my[0]) return 1;
        for (int i = 1; i < mx.size(); i++)
            if (cx == mx[i] && cy == my[i]) return 2;
        return 0;
    endfunction

    task automatic model_edge();
        int nx, ny, oc, op;
        bit self_hit, ate;
        if (rst || game_status == 2'b00) begin
            mx = {}; my = {};
            for (int i = 0; i < INIT_LEN; i++) begin mx.push_back(INIT_X - i); my.push_back(INIT_Y); end
            m_cur = 3; m_pend = 3; m_hw = 0; m_hb = 0; e_snake = 0; e_eat = 0;
        end else begin
            e_snake = m_query(int'(x_pos) / 16, int'(y_pos) / 16);
            e_eat = 0;
            if (game_status == 2'b10) begin
                oc = m_cur; op = m_pend;
                if (move_tick && !m_hw && !m_hb) begin
                    nx = mx[0]; ny = my[0];
                    case (op)
                        0: ny = ny - 1;
                        1: ny = ny + 1;
                        2: nx = nx - 1;
                        default: nx = nx + 1;
                    endcase
                    if (nx == 0 || nx == 39 || ny == 0 || ny == 29) m_hw = 1;
                    else begin
                        self_hit = 0;
                        for (int i = 1; i <= mx.size() - 2; i++)
                            if (mx[i] == nx && my[i] == ny) self_hit = 1;
                        if (self_hit) m_hb = 1;
                        else begin
                            ate = (nx == int'(apple_x)) && (ny == int'(apple_y));
                            if (!(ate && mx.size() < MAX_LEN)) begin void'(mx.pop_back()); void'(my.pop_back()); end
                            mx.push_front(nx); my.push_front(ny);
                            e_eat = ate;
                            m_cur = op;
                        end
                    end
                end
                if (!opposite(int'(dir_in), oc)) m_pend = int'(dir_in);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("snake", int'(snake), e_snake);
        chk("apple_eaten", int'(apple_eaten), e_eat);
        chk("hit_wall", int'(hit_wall), int'(m_hw));
        chk("hit_body", int'(hit_body), int'(m_hb));
        chk("length", int'(length), mx.size());
    endtask

    task automatic qc(input string name, input int cx, input int cy, input int exp);
        x_pos = 10'(cx * 16 + 8); y_pos = 10'(cy * 16 + 8);
        step();
        chk(name, int'(snake), exp);
    endtask

    task automatic tick();
        move_tick = 1'b1; step(); move_tick = 1'b0;
    endtask

    task automatic turn(input logic [1:0] d);
        dir_in = d; step(); tick();
    endtask

    task automatic restart();
        game_status = 2'b00; step(); game_status = 2'b10; dir_in = 2'd3;
    endtask

    initial begin
        tbl[0]  = '{320, 240, 1};  tbl[1]  = '{304, 240, 2};  tbl[2]  = '{288, 240, 2};
        tbl[3]  = '{272, 240, 0};  tbl[4]  = '{0, 0, 3};      tbl[5]  = '{100, 100, 0};
        tbl[6]  = '{639, 100, 3};  tbl[7]  = '{640, 100, 0};  tbl[8]  = '{100, 479, 3};
        tbl[9]  = '{100, 480, 0};  tbl[10] = '{1023, 1023, 0}; tbl[11] = '{336, 240, 0};

        step();
        chk("reset_snake", int'(snake), 0);
        chk("reset_length", int'(length), 3);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            x_pos = 10'(tbl[i].x); y_pos = 10'(tbl[i].y);
            step();
            chk($sformatf("reset_q[%0d]", i), int'(snake), tbl[i].exp);
        end

        // Straight move, then a rejected reversal.
        game_status = 2'b10;
        tick();
        qc("move_head", 21, 15, 1); qc("move_body", 19, 15, 2); qc("move_vacated", 18, 15, 0);
        turn(2'd2);
        qc("rev_head", 22, 15, 1); qc("rev_body", 21, 15, 2);
        dir_in = 2'd3;

        // Growth: eaten pulse lasts one cycle, old tail kept.
        apple_x = 6'd23; apple_y = 5'd15;
        tick();
        chk("eat_pulse", int'(apple_eaten), 1);
        apple_x = 6'd5; apple_y = 5'd5;
        step();
        chk("eat_pulse_end", int'(apple_eaten), 0);
        chk("grow_len", int'(length), 4);
        qc("grow_tail", 20, 15, 2);

        // Wall: run to column 38, then blocked.
        repeat (15) tick();
        qc("pre_wall_head", 38, 15, 1);
        tick();
        chk("hit_wall", int'(hit_wall), 1);
        tick();
        qc("wall_head_kept", 38, 15, 1);
        chk("wall_sticky", int'(hit_wall), 1);
        restart();
        chk("restart_wall", int'(hit_wall), 0);
        qc("restart_head", 20, 15, 1);

        // Length-4 square: entering the vacating tail is legal.
        apple_x = 6'd21; apple_y = 5'd15;
        tick();
        apple_x = 6'd5; apple_y = 5'd5;
        turn(2'd1); turn(2'd2); turn(2'd0);
        chk("tail_no_hit", int'(hit_body), 0);
        qc("tail_head", 20, 15, 1); qc("tail_body", 21, 15, 2); qc("tail_gone", 19, 15, 0);

        // Length-5 square: same turn sequence hits index 3.
        restart();
        apple_x = 6'd21; apple_y = 5'd15; tick();
        apple_x = 6'd22; tick();
        apple_x = 6'd5;
        turn(2'd1); turn(2'd2); turn(2'd0);
        chk("self_hit", int'(hit_body), 1);
        qc("self_head_kept", 21, 16, 1);
        chk("self_len", int'(length), 5);

        // Reset wins over a simultaneous move.
        rst = 1'b1; move_tick = 1'b1; step(); rst = 1'b0; move_tick = 1'b0;
        chk("rst_tick_flag", int'(hit_body), 0);
        qc("rst_tick_head", 20, 15, 1); qc("rst_tick_nomove", 21, 15, 0);

        // Saturation at MAX_LEN.
        restart();
        for (int k = 0; k < 14; k++) begin apple_x = 6'(21 + k); apple_y = 5'd15; tick(); end
        chk("sat_pulse", int'(apple_eaten), 1);
        chk("sat_len", int'(length), MAX_LEN);
        apple_x = 6'd5;

        // Randomized play against the model.
        restart();
        for (int n = 0; n < 4000; n++) begin
            int r, d, k;
            r = $urandom_range(99);
            if ((m_hw || m_hb) && r < 12) game_status = 2'b00;
            else if (r < 2) game_status = 2'b00;
            else if (r < 7) game_status = 2'b01;
            else if (r < 12) game_status = 2'b11;
            else begin
                game_status = 2'b10;
                if ($urandom_range(3) == 0) dir_in = 2'($urandom_range(3));
            end
            move_tick = ($urandom_range(2) == 0);
            if ($urandom_range(2) == 0) begin
                d = m_pend;
                apple_x = 6'(mx[0] + (d == 3 ? 1 : 0) - (d == 2 ? 1 : 0));
                apple_y = 5'(my[0] + (d == 1 ? 1 : 0) - (d == 0 ? 1 : 0));
            end else begin
                apple_x = 6'($urandom_range(39)); apple_y = 5'($urandom_range(29));
            end
            if ($urandom_range(1) == 0) begin
                k = $urandom_range(mx.size() - 1);
                x_pos = 10'(mx[k] * 16 + $urandom_range(15));
                y_pos = 10'(my[k] * 16 + $urandom_range(15));
            end else begin
                x_pos = 10'($urandom_range(1023)); y_pos = 10'($urandom_range(1023));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
